// File: rtl/gm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gm_pkg
//  Brief    : Shared widths, cell encodings and arbiter state type for the
//             graphics-memory arbiter slice.
//  Revision : 1.0  initial release
// ============================================================================
package gm_pkg;

  localparam int GM_ADDR_W = 8;
  localparam int GM_DATA_W = 4;
  localparam int GM_DEPTH  = 256;

  localparam logic [3:0] CELL_UNTAPPED = 4'h0;
  localparam logic [3:0] CELL_MARKED   = 4'h1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    BURST = 2'd2
  } gm_state_e;

endpackage
`default_nettype wire

// File: rtl/gm_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : gm_arbiter_if
//  Brief    : Requester and memory-side signals of the graphics-memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface gm_arbiter_if import gm_pkg::*; #(
  parameter int ADDR_W = GM_ADDR_W,
  parameter int DATA_W = GM_DATA_W
) ();

  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  logic              ctl_req;
  logic              ctl_we;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_gnt;
  logic              ctl_rvalid;
  logic [DATA_W-1:0] ctl_rdata;

  logic              pix_req;
  logic              pix_busy;
  logic              pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_data;
  logic              pix_done;
  logic              pix_abort;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters and the RAM model sit on the master side.
  modport master (
    output clr_req,
    input  clr_busy, clr_done,
    output ctl_req, ctl_we, ctl_addr, ctl_wdata,
    input  ctl_gnt, ctl_rvalid, ctl_rdata,
    output pix_req,
    input  pix_busy, pix_valid, pix_addr, pix_data, pix_done, pix_abort,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  clr_req,
    output clr_busy, clr_done,
    input  ctl_req, ctl_we, ctl_addr, ctl_wdata,
    output ctl_gnt, ctl_rvalid, ctl_rdata,
    input  pix_req,
    output pix_busy, pix_valid, pix_addr, pix_data, pix_done, pix_abort,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/gm_sweep_counter.sv
`default_nettype none
// ============================================================================
//  Module   : gm_sweep_counter
//  Brief    : 0..DEPTH-1 address counter with terminal flag, shared by the
//             clear sweep and the pixel burst.
//  Revision : 1.0  initial release
// ============================================================================
module gm_sweep_counter import gm_pkg::*; #(
  parameter int ADDR_W = GM_ADDR_W,
  parameter int DEPTH  = GM_DEPTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_load,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  // One extra bit so the terminal compare cannot alias through a wrap.
  localparam logic [ADDR_W:0] c_LAST = (ADDR_W + 1)'(DEPTH - 1);

  logic [ADDR_W:0] r_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_last ? '0 : r_count + 1'b1;
    end
  end

  assign o_last = (r_count == c_LAST);
  assign o_addr = r_count[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/gm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gm_arbiter
//  Brief    : Single-port graphics-memory arbiter: clear sweep > controller
//             access > pixel burst, with one-beat fairness inside a burst.
//  Revision : 1.0  initial release
// ============================================================================
module gm_arbiter import gm_pkg::*; #(
  parameter int               ADDR_W   = GM_ADDR_W,
  parameter int               DATA_W   = GM_DATA_W,
  parameter int               DEPTH    = GM_DEPTH,
  parameter logic [DATA_W-1:0] CLR_DATA = CELL_UNTAPPED
) (
  input  logic         clk,
  input  logic         rstn,
  gm_arbiter_if.slave  bus
);

  gm_state_e         r_state;
  logic              r_clr_done;
  logic              r_ctl_last;
  logic              r_pix_armed;
  logic              r_pix_valid;
  logic              r_pix_done;
  logic              r_pix_abort;
  logic [ADDR_W-1:0] r_pix_addr;
  logic [DATA_W-1:0] r_pix_data;
  logic              r_ctl_rvalid;
  logic [DATA_W-1:0] r_ctl_rdata;

  logic              w_clr_start;
  logic              w_pix_start;
  logic              w_abort;
  logic              w_ctl_gnt;
  logic              w_beat;
  logic              w_cnt_load;
  logic              w_cnt_inc;
  logic [ADDR_W-1:0] w_cnt_addr;
  logic              w_cnt_last;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_wdata;

  gm_sweep_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_counter (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_cnt_load),
    .i_inc  (w_cnt_inc),
    .o_addr (w_cnt_addr),
    .o_last (w_cnt_last)
  );

  always_comb begin
    w_clr_start = 1'b0;
    w_pix_start = 1'b0;
    w_abort     = 1'b0;
    w_ctl_gnt   = 1'b0;
    w_beat      = 1'b0;
    w_cnt_inc   = 1'b0;
    w_mem_addr  = '0;
    w_mem_we    = 1'b0;
    w_mem_wdata = '0;
    if (rstn) begin
      case (r_state)
        IDLE: begin
          // The clr_done cycle is held back so a waiting controller is
          // granted strictly after the done pulse.
          if (!r_clr_done) begin
            if (bus.clr_req) begin
              w_clr_start = 1'b1;
            end else if (bus.ctl_req) begin
              w_ctl_gnt = 1'b1;
            end else if (bus.pix_req && r_pix_armed) begin
              w_pix_start = 1'b1;
            end
          end
        end
        CLEAR: begin
          w_mem_we    = 1'b1;
          w_mem_addr  = w_cnt_addr;
          w_mem_wdata = CLR_DATA;
          w_cnt_inc   = 1'b1;
        end
        BURST: begin
          if (bus.clr_req) begin
            w_abort     = 1'b1;
            w_clr_start = 1'b1;
          end else if (bus.ctl_req && !r_ctl_last) begin
            w_ctl_gnt = 1'b1;
          end else begin
            w_beat     = 1'b1;
            w_mem_addr = w_cnt_addr;
            w_cnt_inc  = 1'b1;
          end
        end
        default: ;
      endcase
      if (w_ctl_gnt) begin
        w_mem_addr  = bus.ctl_addr;
        w_mem_we    = bus.ctl_we;
        w_mem_wdata = bus.ctl_wdata;
      end
    end
  end

  assign w_cnt_load = w_clr_start | w_pix_start;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_clr_done   <= 1'b0;
      r_ctl_last   <= 1'b0;
      r_pix_armed  <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_done   <= 1'b0;
      r_pix_abort  <= 1'b0;
      r_pix_addr   <= '0;
      r_pix_data   <= '0;
      r_ctl_rvalid <= 1'b0;
      r_ctl_rdata  <= '0;
    end else begin
      r_clr_done   <= (r_state == CLEAR) && w_cnt_last;
      r_ctl_last   <= w_ctl_gnt && (r_state == BURST);
      r_pix_valid  <= w_beat;
      r_pix_done   <= w_beat && w_cnt_last;
      r_pix_abort  <= w_abort;
      r_ctl_rvalid <= w_ctl_gnt && !bus.ctl_we;
      if (w_ctl_gnt && !bus.ctl_we) begin
        r_ctl_rdata <= bus.mem_rdata;
      end
      if (w_beat) begin
        r_pix_addr <= w_cnt_addr;
        r_pix_data <= bus.mem_rdata;
      end
      // Edge-armed: a held pix_req cannot immediately retransmit.
      if (w_pix_start) begin
        r_pix_armed <= 1'b0;
      end else if (!bus.pix_req) begin
        r_pix_armed <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_clr_start) begin
            r_state <= CLEAR;
          end else if (w_pix_start) begin
            r_state <= BURST;
          end
        end
        CLEAR: begin
          if (w_cnt_last) begin
            r_state <= IDLE;
          end
        end
        BURST: begin
          if (w_clr_start) begin
            r_state <= CLEAR;
          end else if (w_beat && w_cnt_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.clr_busy   = (r_state == CLEAR);
  assign bus.clr_done   = r_clr_done;
  assign bus.ctl_gnt    = w_ctl_gnt;
  assign bus.ctl_rvalid = r_ctl_rvalid;
  assign bus.ctl_rdata  = r_ctl_rdata;
  assign bus.pix_busy   = (r_state == BURST);
  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_addr   = r_pix_addr;
  assign bus.pix_data   = r_pix_data;
  assign bus.pix_done   = r_pix_done;
  assign bus.pix_abort  = r_pix_abort;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_wdata  = w_mem_wdata;

endmodule
`default_nettype wire
